// File: rtl/spi_mem_bridge_if.sv
// rtl/spi_mem_bridge_if.sv - SPI pin and parallel memory port bundle for spi_mem_bridge
interface spi_mem_bridge_if #(
  parameter int ADDR_W = 4
);
  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;

  // Bridge side: consumes SPI pins and memory read data, drives strobes.
  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, mem_rdata,
    output spi_miso, mem_addr, mem_wdata, mem_we, mem_re, busy
  );

  // Host/memory side: drives SPI pins and memory read data.
  modport master (
    output spi_sck, spi_cs_n, spi_mosi, mem_rdata,
    input  spi_miso, mem_addr, mem_wdata, mem_we, mem_re, busy
  );
endinterface

// File: rtl/spi_mem_bridge.sv
// rtl/spi_mem_bridge.sv - SPI mode-0 slave to parallel memory strobe bridge (burst mode: SPI_MEM_BRIDGE_BURST_EN)
module spi_mem_bridge #(
  parameter int RAM_BYTES = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  spi_mem_bridge_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR_DATA,
    S_RD_FETCH,
    S_RD_DATA,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);
  localparam int                ADDR_MASK = (1 << ADDR_W) - 1;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_sck_s;
  logic [1:0]        r_cs_s;
  logic [1:0]        r_mosi_s;
  logic              r_sck_d;
  logic              r_cs_d;

  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_first;
  logic              r_fetch_ph;
  logic [ADDR_W-1:0] r_addr;

  logic              r_miso;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_re;

  logic              w_sck;
  logic              w_cs_n;
  logic              w_mosi;
  logic              w_rise;
  logic              w_fall;
  logic              w_cs_fall;
  logic              w_shift_state;
  logic              w_last;
  logic [7:0]        w_byte;
  logic [1:0]        w_op;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_we_nxt;
  logic              w_re_nxt;
  logic              w_load;

  assign w_sck     = r_sck_s[1];
  assign w_cs_n    = r_cs_s[1];
  assign w_mosi    = r_mosi_s[1];
  // Edges are only seen while enabled; the delayed copy still tracks so no stale edge appears when ena returns.
  assign w_rise    = ena & w_sck & ~r_sck_d;
  assign w_fall    = ena & ~w_sck & r_sck_d;
  assign w_cs_fall = ~w_cs_n & r_cs_d;

  assign w_shift_state = (r_state == S_CMD) || (r_state == S_WR_DATA) || (r_state == S_RD_DATA);
  assign w_last        = w_rise && w_shift_state && (r_bit_cnt == 3'd7);
  assign w_byte        = {r_rx[6:0], w_mosi};
  assign w_op          = w_byte[7:6];
  assign w_cmd_addr    = ADDR_W'((32'(w_byte[3:0]) & ADDR_MASK) % RAM_BYTES);
  assign w_addr_inc    = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;

  assign bus.spi_miso  = r_miso;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.busy      = ~w_cs_n;

  // Two-flop synchronizers plus delayed copies for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s  <= 2'b00;
      r_cs_s   <= 2'b11;
      r_mosi_s <= 2'b00;
      r_sck_d  <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sck_s  <= {r_sck_s[0], bus.spi_sck};
      r_cs_s   <= {r_cs_s[0], bus.spi_cs_n};
      r_mosi_s <= {r_mosi_s[0], bus.spi_mosi};
      r_sck_d  <= w_sck;
      r_cs_d   <= w_cs_n;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decisions; a deasserted chip select overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_re_nxt    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ena && w_cs_fall) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (w_last) begin
          case (w_op)
            2'b01:   w_state_nxt = S_WR_DATA;
            2'b10: begin
              w_state_nxt = S_RD_FETCH;
              w_re_nxt    = 1'b1;
            end
            default: w_state_nxt = S_DRAIN;
          endcase
        end
      end
      S_WR_DATA: begin
        if (w_last) begin
          w_we_nxt = 1'b1;
`ifdef SPI_MEM_BRIDGE_BURST_EN
          w_state_nxt = S_WR_DATA;
`else
          w_state_nxt = S_DRAIN;
`endif
        end
      end
      S_RD_FETCH: begin
        // Phase 0 is the mem_re cycle; memory data is valid in phase 1.
        if (ena && r_fetch_ph) begin
          w_state_nxt = S_RD_DATA;
          w_load      = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (w_last) begin
`ifdef SPI_MEM_BRIDGE_BURST_EN
          w_state_nxt = S_RD_FETCH;
          w_re_nxt    = 1'b1;
`else
          w_state_nxt = S_DRAIN;
`endif
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_DRAIN;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_cs_n) begin
      w_state_nxt = S_IDLE;
      w_we_nxt    = 1'b0;
      w_re_nxt    = 1'b0;
      w_load      = 1'b0;
    end
  end

  // Receive shift register and bit counter; cleared whenever the frame is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= 3'd0;
      r_rx      <= 8'd0;
    end else if (r_state == S_IDLE || w_state_nxt == S_IDLE) begin
      r_bit_cnt <= 3'd0;
      r_rx      <= 8'd0;
    end else if (w_rise && w_shift_state) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_rx      <= w_byte;
    end
  end

  // Address tracking and registered memory strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_mem_we <= w_we_nxt;
      r_mem_re <= w_re_nxt;
      if (r_state == S_CMD && w_last) begin
        r_addr <= w_cmd_addr;
        if (w_re_nxt) r_mem_addr <= w_cmd_addr;
      end
      if (r_state == S_RD_DATA && w_re_nxt) begin
        r_addr     <= w_addr_inc;
        r_mem_addr <= w_addr_inc;
      end
      if (w_we_nxt) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= w_byte;
        r_addr      <= w_addr_inc;
      end
    end
  end

  // Read fetch phase and transmit shifter; the first fall after a load presents bit 7 without shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_ph <= 1'b0;
      r_tx       <= 8'd0;
      r_first    <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      if (r_state != S_RD_FETCH || w_load) begin
        r_fetch_ph <= 1'b0;
      end else if (ena) begin
        r_fetch_ph <= 1'b1;
      end
      if (w_state_nxt != S_RD_FETCH && w_state_nxt != S_RD_DATA) begin
        r_miso  <= 1'b0;
        r_first <= 1'b0;
      end else if (w_load) begin
        r_tx    <= bus.mem_rdata;
        r_first <= 1'b1;
      end else if (w_fall && r_state == S_RD_DATA) begin
        if (r_first) begin
          r_miso  <= r_tx[7];
          r_first <= 1'b0;
        end else begin
          r_miso <= r_tx[6];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb/tb_spi_mem_bridge.sv - directed scoreboard bench for spi_mem_bridge
module tb_spi_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;

  int checks = 0;
  int errors = 0;
  int miso_hi = 0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [7:0]  mem [16] = '{default: 8'h00};

  spi_mem_bridge_if #(.ADDR_W(4)) bus ();

  spi_mem_bridge #(.RAM_BYTES(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Registered memory model: read data appears one clk after mem_re.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Scoreboard: every strobe pops the expectation pushed by the stimulus.
  always @(negedge clk) begin
    logic [11:0] ew;
    logic [3:0]  er;
    if (rst_n) begin
      if (bus.mem_we && bus.mem_re) check("we_re_overlap", {31'd0, bus.mem_re}, 32'd0);
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_we", 32'(exp_wr.size()), 32'd1);
        end else begin
          ew = exp_wr.pop_front();
          check("we_addr", 32'(bus.mem_addr), 32'(ew[11:8]));
          check("we_data", 32'(bus.mem_wdata), 32'(ew[7:0]));
        end
      end
      if (bus.mem_re) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_re", 32'(exp_rd.size()), 32'd1);
        end else begin
          er = exp_rd.pop_front();
          check("re_addr", 32'(bus.mem_addr), 32'(er));
        end
      end
      if (bus.spi_miso === 1'b1) miso_hi++;
    end
  end

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      #50;
      bus.spi_sck = 1'b1;
      rx[i] = bus.spi_miso;
      #50;
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40;
    bus.spi_cs_n = 1'b1;
    #80;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_miso"},  32'(bus.spi_miso),  32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_re"},    32'(bus.mem_re),    32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    int         hi0;
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;

    #23;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #50;

    // WRITE 0xA5 to address 5
    exp_wr.push_back({4'd5, 8'hA5});
    cs_low();
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    spi_xfer(8'h45, 8, rx);
    spi_xfer(8'hA5, 8, rx);
    cs_high();
    check("wr5_pending", 32'(exp_wr.size()), 32'd0);

    // READ address 5, eight dummy clocks
    exp_rd.push_back(4'd5);
`ifdef SPI_MEM_BRIDGE_BURST_EN
    exp_rd.push_back(4'd6);
`endif
    cs_low();
    spi_xfer(8'h85, 8, rx);
    check("rd_cmd_miso", 32'(rx), 32'd0);
    spi_xfer(8'h00, 8, rx);
    check("rd5_data", 32'(rx), 32'hA5);
    cs_high();
    check("rd5_pending", 32'(exp_rd.size()), 32'd0);

    // Partial data byte aborted by chip select, then a good write
    cs_low();
    spi_xfer(8'h43, 8, rx);
    spi_xfer(8'h3C, 5, rx);
    cs_high();
    check("abort_busy", 32'(bus.busy), 32'd0);
    exp_wr.push_back({4'd3, 8'h3C});
    cs_low();
    spi_xfer(8'h43, 8, rx);
    spi_xfer(8'h3C, 8, rx);
    cs_high();
    check("wr3_pending", 32'(exp_wr.size()), 32'd0);

    // Invalid opcode: no strobes, MISO quiet
    hi0 = miso_hi;
    cs_low();
    spi_xfer(8'h07, 8, rx);
    check("inv_rx0", 32'(rx), 32'd0);
    spi_xfer(8'hFF, 8, rx);
    check("inv_rx1", 32'(rx), 32'd0);
    cs_high();
    check("inv_miso_quiet", 32'(miso_hi - hi0), 32'd0);

    // Write at the last address, with a second data byte
    exp_wr.push_back({4'd15, 8'h11});
`ifdef SPI_MEM_BRIDGE_BURST_EN
    exp_wr.push_back({4'd0, 8'h22});
`endif
    cs_low();
    spi_xfer(8'h4F, 8, rx);
    spi_xfer(8'h11, 8, rx);
    spi_xfer(8'h22, 8, rx);
    cs_high();
    check("wr15_pending", 32'(exp_wr.size()), 32'd0);

    // Disabled: a whole write frame is ignored
    ena = 1'b0;
    cs_low();
    spi_xfer(8'h42, 8, rx);
    spi_xfer(8'h77, 8, rx);
    cs_high();
    ena = 1'b1;
    check("ena_off_pending", 32'(exp_wr.size() + exp_rd.size()), 32'd0);

    // Asynchronous reset in the middle of a data byte
    cs_low();
    spi_xfer(8'h41, 8, rx);
    spi_xfer(8'h99, 4, rx);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spi_xfer(8'h99, 4, rx);
    cs_high();

    // Normal operation afterwards: write then read back address 9
    exp_wr.push_back({4'd9, 8'h5A});
    cs_low();
    spi_xfer(8'h49, 8, rx);
    spi_xfer(8'h5A, 8, rx);
    cs_high();
    check("wr9_pending", 32'(exp_wr.size()), 32'd0);
    exp_rd.push_back(4'd9);
`ifdef SPI_MEM_BRIDGE_BURST_EN
    exp_rd.push_back(4'd10);
`endif
    cs_low();
    spi_xfer(8'h89, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("rd9_data", 32'(rx), 32'h5A);
    cs_high();
    check("rd9_pending", 32'(exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
